// File: rtl/deco_exe_reg_if.sv
// Decode/execute pipeline-register bus: decode-side inputs, execute-side
// outputs and the trig-unit handshake grouped into one interface.
interface deco_exe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    // Decode-stage side
    logic              valid_d;
    logic [14:0]       ctrl_d;
    logic              blink_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic [DATA_W-1:0] imm_d;
    logic [REG_AW-1:0] ra1_d;
    logic [REG_AW-1:0] ra2_d;
    logic [REG_AW-1:0] wa3_d;
    logic              stall_d;
    logic              flush_e;
    logic              trig_done;

    // Execute-stage side
    logic              valid_e;
    logic [14:0]       ctrl_e;
    logic              blink_e;
    logic [DATA_W-1:0] rd1_e;
    logic [DATA_W-1:0] rd2_e;
    logic [DATA_W-1:0] imm_e;
    logic [REG_AW-1:0] ra1_e;
    logic [REG_AW-1:0] ra2_e;
    logic [REG_AW-1:0] wa3_e;
    logic              trig_start;
    logic              hold_de;
    logic              trig_err;

    // Pipeline / environment view: drives decode side, observes execute side
    modport master (
        output valid_d, ctrl_d, blink_d, rd1_d, rd2_d, imm_d,
               ra1_d, ra2_d, wa3_d, stall_d, flush_e, trig_done,
        input  valid_e, ctrl_e, blink_e, rd1_e, rd2_e, imm_e,
               ra1_e, ra2_e, wa3_e, trig_start, hold_de, trig_err
    );

    // Register view
    modport slave (
        input  valid_d, ctrl_d, blink_d, rd1_d, rd2_d, imm_d,
               ra1_d, ra2_d, wa3_d, stall_d, flush_e, trig_done,
        output valid_e, ctrl_e, blink_e, rd1_e, rd2_e, imm_e,
               ra1_e, ra2_e, wa3_e, trig_start, hold_de, trig_err
    );
endinterface

// File: rtl/deco_exe_reg.sv
// Decode->execute pipeline register for the PDA core. Captures the decode
// control bundle and operands, applies stall/flush, and sequences the
// multi-cycle SIN/COS handshake by holding E while the trig unit runs.
//
// ctrl bundle bit map (MSB..LSB):
//   [14] pcSrc  [13] regWrite  [12] immSrc  [11] aluSrc  [10] trigControl
//   [9:6] aluControl  [5] memWrite  [4] memPixWrite  [3:2] memToReg
//   [1] branch  [0] flagWrite
module deco_exe_reg #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 4,
    parameter int TRIG_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    deco_exe_reg_if.slave  bus
);
    localparam int CTRL_W   = 15;
    localparam int TRIG_BIT = 10;

    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_TRIG_WAIT = 1'b1;

    localparam int              CNT_W    = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRIG_TIMEOUT - 1);

    // FSM / handshake state
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_start_q, trig_start_d;
    logic             trig_err_q, trig_err_d;

    // E-stage payload
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              blink_q, blink_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] ra1_q, ra1_d;
    logic [REG_AW-1:0] ra2_q, ra2_d;
    logic [REG_AW-1:0] wa3_q, wa3_d;

    // Control decode shared by the payload and FSM next-state logic
    logic in_wait;
    logic timeout;
    logic release_w;
    logic e_update;
    logic do_flush;
    logic do_load;
    logic enter_wait;

    assign in_wait    = (state_q == ST_TRIG_WAIT);
    // A timeout releases E exactly as a trig_done would
    assign timeout    = in_wait && (cnt_q == CNT_LAST);
    assign release_w  = in_wait && (bus.trig_done || timeout);
    // E follows the normal flush/stall/load rules in IDLE and on the release edge
    assign e_update   = !in_wait || release_w;
    assign do_flush   = e_update && bus.flush_e;
    assign do_load    = e_update && !bus.flush_e && !bus.stall_d;
    assign enter_wait = do_load && bus.valid_d && bus.ctrl_d[TRIG_BIT];

    // Next E payload: flush beats stall beats load; otherwise hold
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        blink_d = blink_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        ra1_d   = ra1_q;
        ra2_d   = ra2_q;
        wa3_d   = wa3_q;
        if (do_flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            blink_d = 1'b0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            ra1_d   = '0;
            ra2_d   = '0;
            wa3_d   = '0;
        end else if (do_load) begin
            valid_d = bus.valid_d;
            ctrl_d  = bus.valid_d ? bus.ctrl_d  : '0;
            blink_d = bus.valid_d ? bus.blink_d : 1'b0;
            rd1_d   = bus.rd1_d;
            rd2_d   = bus.rd2_d;
            imm_d   = bus.imm_d;
            ra1_d   = bus.ra1_d;
            ra2_d   = bus.ra2_d;
            wa3_d   = bus.wa3_d;
        end
    end

    // Trig FSM, wait counter, start pulse and sticky timeout flag
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trig_start_d = enter_wait;
        trig_err_d   = trig_err_q | timeout;
        if (enter_wait) begin
            state_d = ST_TRIG_WAIT;
            cnt_d   = '0;
        end else if (release_w) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (in_wait) begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // State and payload registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            trig_start_q <= 1'b0;
            trig_err_q   <= 1'b0;
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            blink_q      <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            ra1_q        <= '0;
            ra2_q        <= '0;
            wa3_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trig_start_q <= trig_start_d;
            trig_err_q   <= trig_err_d;
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            blink_q      <= blink_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            ra1_q        <= ra1_d;
            ra2_q        <= ra2_d;
            wa3_q        <= wa3_d;
        end
    end

    assign bus.valid_e    = valid_q;
    assign bus.ctrl_e     = ctrl_q;
    assign bus.blink_e    = blink_q;
    assign bus.rd1_e      = rd1_q;
    assign bus.rd2_e      = rd2_q;
    assign bus.imm_e      = imm_q;
    assign bus.ra1_e      = ra1_q;
    assign bus.ra2_e      = ra2_q;
    assign bus.wa3_e      = wa3_q;
    assign bus.trig_start = trig_start_q;
    assign bus.trig_err   = trig_err_q;
    // Drops in the release cycle itself so decode advances with no bubble
    assign bus.hold_de    = in_wait && !(bus.trig_done || timeout);
endmodule
